cache_refill_unit: RTL and testbench
====================================

// Module: cache_refill_unit
// PURPOSE
// - Miss handler that sits directly downstream of the two-way LRU data cache.
// - On a CPU access that misses, it stalls the core and fetches the whole block
//   from main memory as a burst.
// - Each returned word is written into the victim way picked by the replacement
//   unit. The line is then committed (tag + valid) and the LRU state updated.
// - Stall releases after commit; the core re-presents the access, which then hits.
// PARAMETERS
// - ADDR_SIZE        32  byte-address width
// - NUM_SETS         16  sets in the cache (power of 2)
// - NUM_WAYS          2  ways; width of way index = $clog2(NUM_WAYS)
// - WORDS_PER_BLOCK   4  32-bit words per block (power of 2, >=2)
// PORTS
// - clk             in   1   clock (rising edge)
// - rst             in   1   reset, synchronous, active-high
// - req_valid       in   1   CPU load/store presented this cycle
// - req_addr        in   ADDR_SIZE  CPU byte address
// - cache_hit       in   1   hit flag from cache memory for req_addr
// - replace_way     in   $clog2(NUM_WAYS)  victim way from replacement unit
// - stall           out  1   freeze CPU pipeline
// - mem_req_valid   out  1   burst read request to main memory
// - mem_req_ready   in   1   memory accepts request
// - mem_req_addr    out  ADDR_SIZE  first word address of burst (word aligned)
// - mem_rsp_valid   in   1   one data beat returned
// - mem_rsp_data    in   32  beat data
// - fill_we         out  1   write fill_data into cache data array
// - fill_way        out  $clog2(NUM_WAYS)  latched victim way
// - fill_set        out  $clog2(NUM_SETS)  latched set index
// - fill_tag        out  tag width  latched tag = ADDR_SIZE-set-word-2 bits
// - fill_word       out  $clog2(WORDS_PER_BLOCK)  word index within block
// - fill_data       out  32  = mem_rsp_data
// - fill_commit     out  1   one-cycle pulse: write tag, set valid for fill_way/set
// - cru_update      out  1   one-cycle pulse (same cycle as commit): mark way MRU
// BEHAVIOUR
// - Address split: [1:0] byte, then word index, then set, then tag (MSBs).
// - FSM states: IDLE, REQ, RECV, COMMIT.
// - IDLE: on req_valid && !cache_hit, stall=1 combinationally that cycle.
//   Latch addr fields and replace_way, then go to REQ. No miss -> stay, stall=0.
// - REQ: mem_req_valid=1 with mem_req_addr held stable until mem_req_ready.
//   Handshake cycle: beat counter cleared, then go to RECV.
// - RECV: each mem_rsp_valid -> fill_we=1 in the same cycle,
//   fill_word=(start+count) mod WORDS_PER_BLOCK, count++.
//   The beat where count==WORDS_PER_BLOCK-1 goes to COMMIT. Gaps between beats allowed.
// - COMMIT: fill_commit=1, cru_update=1 for one cycle, stall=1; next state IDLE.
// - stall=1 in REQ, RECV and COMMIT; 0 in the IDLE cycle after COMMIT.
// - Min miss penalty with ready/rsp immediate: 1 (detect) + 1 (REQ) + WORDS_PER_BLOCK + 1 (COMMIT).
// - Inputs req_valid/addr/hit/replace_way are ignored outside IDLE.
//   Latched values are held for the whole refill.
// - mem_rsp_valid outside RECV is ignored (no fill_we).
// - Counter is $clog2(WORDS_PER_BLOCK) bits and wraps naturally.
// - Reset (any state, including mid-burst): state=IDLE, counter=0.
//   All outputs 0 the following cycle; no commit is issued, so the line stays invalid.
// - Reset outputs: stall, mem_req_valid, fill_we, fill_commit, cru_update = 0.
//   Address/field outputs = 0.
// CONFIGURATION
// - CACHE_REFILL_CRITICAL_WORD_FIRST_EN defined: start = requested word index.
//   mem_req_addr = req_addr word-aligned; fill_word wraps past the block end.
// - Undefined: start = 0; mem_req_addr = block base (word-index bits zero).
//   fill_word = 0..WORDS_PER_BLOCK-1.
// TESTING
// - Hit: req_valid=1, hit=1 for 10 cycles -> stall=0, mem_req_valid never asserted.
// - Miss 0x0000_1234, replace_way=1, ready/rsp immediate (macro off) ->
//   mem_req_addr=0x1230; fill_word 0,1,2,3; fill_set=3, fill_way=1.
//   fill_commit+cru_update one cycle; stall high exactly 7 cycles.
// - Same miss with CACHE_REFILL_CRITICAL_WORD_FIRST_EN -> mem_req_addr=0x1234,
//   fill_word 1,2,3,0.
// - mem_req_ready low 5 cycles, rsp beats spaced 3 cycles apart ->
//   addr held stable, exactly 4 fill_we pulses, one commit.
// - rst=1 after 2nd beat -> next cycle stall=0, no fill_commit.
//   A new miss afterwards refills normally.
// - mem_rsp_valid pulsed in IDLE and REQ -> no fill_we, counter unchanged.

Source files
------------

// File: rtl/cache_refill_unit.sv
// Miss handler for the two-way data cache: bursts a block from memory into the victim way.
// Define CACHE_REFILL_CRITICAL_WORD_FIRST_EN to start the burst at the requested word.
module cache_refill_unit #(
    parameter int ADDR_SIZE       = 32,
    parameter int NUM_SETS        = 16,
    parameter int NUM_WAYS        = 2,
    parameter int WORDS_PER_BLOCK = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               req_valid,
    input  logic [ADDR_SIZE-1:0]               req_addr,
    input  logic                               cache_hit,
    input  logic [$clog2(NUM_WAYS)-1:0]        replace_way,
    output logic                               stall,
    output logic                               mem_req_valid,
    input  logic                               mem_req_ready,
    output logic [ADDR_SIZE-1:0]               mem_req_addr,
    input  logic                               mem_rsp_valid,
    input  logic [31:0]                        mem_rsp_data,
    output logic                               fill_we,
    output logic [$clog2(NUM_WAYS)-1:0]        fill_way,
    output logic [$clog2(NUM_SETS)-1:0]        fill_set,
    output logic [ADDR_SIZE-$clog2(NUM_SETS)-$clog2(WORDS_PER_BLOCK)-3:0] fill_tag,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word,
    output logic [31:0]                        fill_data,
    output logic                               fill_commit,
    output logic                               cru_update
);

    localparam int WAY_W  = $clog2(NUM_WAYS);
    localparam int WORD_W = $clog2(WORDS_PER_BLOCK);
    localparam int SET_W  = $clog2(NUM_SETS);
    localparam int TAG_W  = ADDR_SIZE - SET_W - WORD_W - 2;
    localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(WORDS_PER_BLOCK - 1);

    typedef enum logic [1:0] {IDLE, REQ, RECV, COMMIT} state_t;

    state_t             state;
    logic [WORD_W-1:0]  beat_count;
    logic [WORD_W-1:0]  start_word;
    logic [SET_W-1:0]   set_q;
    logic [TAG_W-1:0]   tag_q;
    logic [WAY_W-1:0]   way_q;

    logic               miss;
    logic [WORD_W-1:0]  req_word;
    logic [SET_W-1:0]   req_set;
    logic [TAG_W-1:0]   req_tag;
    logic [WORD_W+1:0]  unused_low_bits;

    assign miss     = req_valid && !cache_hit;
    assign req_word = req_addr[WORD_W+1:2];
    assign req_set  = req_addr[SET_W+WORD_W+1:WORD_W+2];
    assign req_tag  = req_addr[ADDR_SIZE-1:SET_W+WORD_W+2];
    // Byte offset never matters, and the word index only matters with critical-word-first.
    assign unused_low_bits = req_addr[WORD_W+1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            beat_count <= '0;
            start_word <= '0;
            set_q      <= '0;
            tag_q      <= '0;
            way_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss) begin
                        set_q <= req_set;
                        tag_q <= req_tag;
                        way_q <= replace_way;
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
                        start_word <= req_word;
`else
                        start_word <= '0;
`endif
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        beat_count <= '0;
                        state      <= RECV;
                    end
                end
                RECV: begin
                    if (mem_rsp_valid) begin
                        beat_count <= beat_count + 1'b1;
                        if (beat_count == LAST_BEAT) begin
                            state <= COMMIT;
                        end
                    end
                end
                COMMIT: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // The stall must rise in the detect cycle itself, before the FSM leaves IDLE.
    assign stall         = (state != IDLE) || miss;
    assign mem_req_valid = (state == REQ);
    assign mem_req_addr  = {tag_q, set_q, start_word, 2'b00};
    assign fill_we       = (state == RECV) && mem_rsp_valid;
    assign fill_way      = way_q;
    assign fill_set      = set_q;
    assign fill_tag      = tag_q;
    assign fill_word     = start_word + beat_count;
    assign fill_data     = fill_we ? mem_rsp_data : 32'h0;
    assign fill_commit   = (state == COMMIT);
    assign cru_update    = (state == COMMIT);

endmodule

// File: tb/tb_cache_refill_unit.sv
// Directed testbench for cache_refill_unit: hit passthrough, refills, memory backpressure and reset abort.
module tb_cache_refill_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        cache_hit;
    logic [0:0]  replace_way;
    logic        stall;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        fill_we;
    logic [0:0]  fill_way;
    logic [3:0]  fill_set;
    logic [23:0] fill_tag;
    logic [1:0]  fill_word;
    logic [31:0] fill_data;
    logic        fill_commit;
    logic        cru_update;

    int n_compared   = 0;
    int n_mismatched = 0;

`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
    localparam logic [31:0] EXP_ADDR_1234 = 32'h0000_1234;
    localparam logic [31:0] EXP_ADDR_ABC8 = 32'h0000_ABC8;
    localparam int          START_1234    = 1;
    localparam int          START_ABC8    = 2;
`else
    localparam logic [31:0] EXP_ADDR_1234 = 32'h0000_1230;
    localparam logic [31:0] EXP_ADDR_ABC8 = 32'h0000_ABC0;
    localparam int          START_1234    = 0;
    localparam int          START_ABC8    = 0;
`endif

    // Observations gathered by run_refill for the calling test to judge.
    int          obs_stall;
    int          obs_we;
    int          obs_commit;
    int          obs_update;
    int          obs_words [8];
    logic [31:0] obs_addr;
    bit          obs_addr_stable;
    bit          obs_data_ok;
    bit          obs_fields_ok;
    bit          obs_pair_ok;
    bit          obs_timeout;
    logic        obs_stall_after;

    cache_refill_unit dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .cache_hit(cache_hit), .replace_way(replace_way), .stall(stall),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data), .fill_we(fill_we), .fill_way(fill_way),
        .fill_set(fill_set), .fill_tag(fill_tag), .fill_word(fill_word),
        .fill_data(fill_data), .fill_commit(fill_commit), .cru_update(cru_update)
    );

    always #5 clk = ~clk;

    // Presents one miss, then plays a memory that raises ready after ready_delay
    // request cycles and returns beats with gap idle cycles between them.
    task automatic run_refill(input logic [31:0] addr, input logic [0:0] way,
                              input int ready_delay, input int gap,
                              input logic [3:0] exp_set, input logic [23:0] exp_tag);
        int reqcnt = 0;
        int gapcnt = 0;
        int beats  = 0;
        int cyc    = 0;
        bit hs_done = 0;
        bit commit_seen = 0;
        bit done = 0;
        obs_stall = 0; obs_we = 0; obs_commit = 0; obs_update = 0;
        obs_addr = 32'h0; obs_addr_stable = 1; obs_data_ok = 1; obs_fields_ok = 1;
        obs_pair_ok = 1; obs_stall_after = 1'bx;
        for (int i = 0; i < 8; i++) obs_words[i] = -1;
        @(negedge clk);
        req_valid = 1; req_addr = addr; cache_hit = 0; replace_way = way;
        mem_req_ready = 0; mem_rsp_valid = 0;
        #1;
        if (stall) obs_stall++;
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            req_valid = 0; req_addr = 32'hFFFF_FFFC; replace_way = ~way;
            mem_req_ready = mem_req_valid && (reqcnt >= ready_delay);
            if (hs_done && beats < 4 && gapcnt == 0) begin
                mem_rsp_valid = 1; mem_rsp_data = 32'hA5A5_0000 + beats;
            end else begin
                mem_rsp_valid = 0; mem_rsp_data = 32'hDEAD_BEEF;
            end
            #1;
            if (commit_seen) begin
                obs_stall_after = stall;
                done = 1;
            end
            if (stall) obs_stall++;
            if (mem_req_valid) begin
                if (reqcnt == 0) obs_addr = mem_req_addr;
                else if (mem_req_addr !== obs_addr) obs_addr_stable = 0;
                reqcnt++;
                if (mem_req_ready) hs_done = 1;
            end
            if (fill_we) begin
                if (obs_we < 8) obs_words[obs_we] = int'(fill_word);
                if (fill_data !== mem_rsp_data) obs_data_ok = 0;
                if (fill_set !== exp_set || fill_tag !== exp_tag || fill_way !== way) obs_fields_ok = 0;
                obs_we++;
            end
            if (fill_commit) begin obs_commit++; commit_seen = 1; end
            if (cru_update) obs_update++;
            if (fill_commit !== cru_update) obs_pair_ok = 0;
            if (mem_rsp_valid) begin beats++; gapcnt = gap; end
            else if (gapcnt > 0) gapcnt--;
        end
        obs_timeout = !done;
        mem_req_ready = 0; mem_rsp_valid = 0;
    endtask

    task automatic test_reset();
        rst = 1; req_valid = 0; req_addr = 0; cache_hit = 0; replace_way = 0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        n_compared++;
        if ({stall, mem_req_valid, fill_we, fill_commit, cru_update} !== 5'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_ctrl: got %b expected 00000", {stall, mem_req_valid, fill_we, fill_commit, cru_update});
        end
        n_compared++;
        if (mem_req_addr !== 32'h0 || fill_set !== 4'h0 || fill_tag !== 24'h0 || fill_way !== 1'b0 || fill_word !== 2'd0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_fields: got addr=%h set=%0d tag=%h way=%0d word=%0d expected all zero",
                     mem_req_addr, fill_set, fill_tag, fill_way, fill_word);
        end
    endtask

    task automatic test_hit();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            req_valid = 1; req_addr = 32'h0000_1234; cache_hit = 1; replace_way = 1;
            #1;
            n_compared++;
            if (stall !== 1'b0 || mem_req_valid !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL hit_cycle%0d: got stall=%b mem_req_valid=%b expected 0/0", i, stall, mem_req_valid);
            end
        end
        req_valid = 0; cache_hit = 0;
    endtask

    task automatic test_miss_immediate();
        run_refill(32'h0000_1234, 1'b1, 0, 0, 4'd3, 24'h000012);
        n_compared++;
        if (obs_timeout) begin n_mismatched++; $display("[TB] FAIL imm_timeout: got timeout expected commit"); end
        n_compared++;
        if (obs_stall !== 7) begin n_mismatched++; $display("[TB] FAIL imm_stall_cycles: got %0d expected 7", obs_stall); end
        n_compared++;
        if (obs_addr !== EXP_ADDR_1234) begin n_mismatched++; $display("[TB] FAIL imm_mem_addr: got %h expected %h", obs_addr, EXP_ADDR_1234); end
        n_compared++;
        if (obs_we !== 4) begin n_mismatched++; $display("[TB] FAIL imm_we_count: got %0d expected 4", obs_we); end
        for (int i = 0; i < 4; i++) begin
            n_compared++;
            if (obs_words[i] !== (START_1234 + i) % 4) begin
                n_mismatched++;
                $display("[TB] FAIL imm_word%0d: got %0d expected %0d", i, obs_words[i], (START_1234 + i) % 4);
            end
        end
        n_compared++;
        if (!obs_data_ok || !obs_fields_ok) begin
            n_mismatched++;
            $display("[TB] FAIL imm_fill_fields: got data_ok=%0d fields_ok=%0d expected 1/1 (set 3, way 1, tag 12)", obs_data_ok, obs_fields_ok);
        end
        n_compared++;
        if (obs_commit !== 1 || obs_update !== 1 || !obs_pair_ok) begin
            n_mismatched++;
            $display("[TB] FAIL imm_commit: got commit=%0d update=%0d paired=%0d expected 1/1/1", obs_commit, obs_update, obs_pair_ok);
        end
        n_compared++;
        if (obs_stall_after !== 1'b0) begin n_mismatched++; $display("[TB] FAIL imm_stall_release: got %b expected 0", obs_stall_after); end
    endtask

    task automatic test_stalled_memory();
        run_refill(32'h0000_ABC8, 1'b0, 5, 2, 4'd12, 24'h0000AB);
        n_compared++;
        if (obs_timeout) begin n_mismatched++; $display("[TB] FAIL slow_timeout: got timeout expected commit"); end
        n_compared++;
        if (obs_addr !== EXP_ADDR_ABC8 || !obs_addr_stable) begin
            n_mismatched++;
            $display("[TB] FAIL slow_mem_addr: got %h stable=%0d expected %h stable=1", obs_addr, obs_addr_stable, EXP_ADDR_ABC8);
        end
        n_compared++;
        if (obs_stall !== 18) begin n_mismatched++; $display("[TB] FAIL slow_stall_cycles: got %0d expected 18", obs_stall); end
        n_compared++;
        if (obs_we !== 4 || obs_commit !== 1) begin
            n_mismatched++;
            $display("[TB] FAIL slow_pulses: got we=%0d commit=%0d expected 4/1", obs_we, obs_commit);
        end
        for (int i = 0; i < 4; i++) begin
            n_compared++;
            if (obs_words[i] !== (START_ABC8 + i) % 4) begin
                n_mismatched++;
                $display("[TB] FAIL slow_word%0d: got %0d expected %0d", i, obs_words[i], (START_ABC8 + i) % 4);
            end
        end
        n_compared++;
        if (!obs_data_ok || !obs_fields_ok) begin
            n_mismatched++;
            $display("[TB] FAIL slow_fill_fields: got data_ok=%0d fields_ok=%0d expected 1/1", obs_data_ok, obs_fields_ok);
        end
    endtask

    task automatic test_stray_rsp();
        @(negedge clk);
        req_valid = 1; req_addr = 32'h0000_1234; cache_hit = 0; replace_way = 1;
        mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h1111_1111;
        #1;
        n_compared++;
        if (fill_we !== 1'b0) begin n_mismatched++; $display("[TB] FAIL stray_idle_we: got %b expected 0", fill_we); end
        @(negedge clk);
        req_valid = 0; mem_req_ready = 0; mem_rsp_valid = 1;
        #1;
        n_compared++;
        if (fill_we !== 1'b0 || mem_req_valid !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL stray_req_we: got we=%b req_valid=%b expected 0/1", fill_we, mem_req_valid);
        end
        @(negedge clk);
        mem_req_ready = 1; mem_rsp_valid = 1;
        #1;
        n_compared++;
        if (fill_we !== 1'b0) begin n_mismatched++; $display("[TB] FAIL stray_handshake_we: got %b expected 0", fill_we); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h2222_0000 + i;
            #1;
            n_compared++;
            if (fill_we !== 1'b1 || int'(fill_word) !== (START_1234 + i) % 4) begin
                n_mismatched++;
                $display("[TB] FAIL stray_beat%0d: got we=%b word=%0d expected 1/%0d", i, fill_we, fill_word, (START_1234 + i) % 4);
            end
        end
        @(negedge clk);
        mem_rsp_valid = 0;
        #1;
        n_compared++;
        if (fill_commit !== 1'b1) begin n_mismatched++; $display("[TB] FAIL stray_commit: got %b expected 1", fill_commit); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_burst();
        int commits = 0;
        int wes = 0;
        @(negedge clk);
        req_valid = 1; req_addr = 32'h0000_1234; cache_hit = 0; replace_way = 1;
        mem_req_ready = 0; mem_rsp_valid = 0;
        @(negedge clk);
        req_valid = 0; mem_req_ready = 1;
        @(negedge clk);
        mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h3333_0000;
        @(negedge clk);
        mem_rsp_data = 32'h3333_0001;
        #1;
        n_compared++;
        if (fill_we !== 1'b1) begin n_mismatched++; $display("[TB] FAIL abort_second_beat: got %b expected 1", fill_we); end
        @(negedge clk);
        mem_rsp_valid = 0; rst = 1;
        @(negedge clk);
        rst = 0;
        #1;
        n_compared++;
        if ({stall, mem_req_valid, fill_commit, cru_update} !== 4'b0 || fill_set !== 4'h0 || fill_way !== 1'b0 || fill_tag !== 24'h0) begin
            n_mismatched++;
            $display("[TB] FAIL abort_outputs: got ctrl=%b set=%0d way=%0d tag=%h expected all zero",
                     {stall, mem_req_valid, fill_commit, cru_update}, fill_set, fill_way, fill_tag);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            mem_rsp_valid = 1; mem_rsp_data = 32'h4444_0000 + i;
            #1;
            if (fill_commit) commits++;
            if (fill_we) wes++;
        end
        mem_rsp_valid = 0;
        n_compared++;
        if (commits !== 0 || wes !== 0) begin
            n_mismatched++;
            $display("[TB] FAIL abort_no_commit: got commits=%0d we=%0d expected 0/0", commits, wes);
        end
        run_refill(32'h0000_0040, 1'b1, 0, 0, 4'd4, 24'h000000);
        n_compared++;
        if (obs_timeout || obs_stall !== 7 || obs_we !== 4 || obs_commit !== 1 || obs_addr !== 32'h0000_0040) begin
            n_mismatched++;
            $display("[TB] FAIL abort_recovery: got timeout=%0d stall=%0d we=%0d commit=%0d addr=%h expected 0/7/4/1/00000040",
                     obs_timeout, obs_stall, obs_we, obs_commit, obs_addr);
        end
        n_compared++;
        if (!obs_fields_ok || obs_words[0] !== 0 || obs_words[3] !== 3) begin
            n_mismatched++;
            $display("[TB] FAIL abort_recovery_fields: got fields_ok=%0d w0=%0d w3=%0d expected 1/0/3",
                     obs_fields_ok, obs_words[0], obs_words[3]);
        end
    endtask

    initial begin
        test_reset();
        test_hit();
        test_miss_immediate();
        test_stalled_memory();
        test_stray_rsp();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
